// File: rtl/barret_reduce_pipe_if.sv
// Operand/result handshake bundle for barret_reduce_pipe.
// slave is the reducer side, master is the producer/consumer side.
interface barret_reduce_pipe_if #(
    parameter int DW   = 14,
    parameter int QW   = 7,
    parameter int TAGW = 4,
    parameter int CNTW = 16
);
    logic            din_valid;
    logic            din_ready;
    logic [DW-1:0]   din_a;
    logic [TAGW-1:0] din_tag;
    logic            dout_valid;
    logic            dout_ready;
    logic [QW-1:0]   dout_r;
    logic [TAGW-1:0] dout_tag;
    logic [CNTW-1:0] res_cnt;

    modport master (
        output din_valid, din_a, din_tag, dout_ready,
        input  din_ready, dout_valid, dout_r, dout_tag, res_cnt
    );

    modport slave (
        input  din_valid, din_a, din_tag, dout_ready,
        output din_ready, dout_valid, dout_r, dout_tag, res_cnt
    );
endinterface

// File: rtl/barret_reduce_pipe.sv
// Three-stage Barrett reducer: dout_r = din_a mod Q with valid/ready flow control,
// a sideband tag carried alongside each operand and a count of delivered results.
module barret_reduce_pipe #(
    parameter int Q    = 103,
    parameter int QW   = 7,
    parameter int DW   = 2*QW,
    parameter int MU   = (2**DW)/Q,
    parameter int TAGW = 4,
    parameter int CNTW = 16
) (
    input logic               clk,
    input logic               rst_n,
    barret_reduce_pipe_if.slave bus
);
    localparam int MUL_W = 2*DW;
    localparam int R0W   = QW+2;
    localparam logic [R0W-1:0] Q_R  = R0W'(Q);
    localparam logic [R0W-1:0] Q2_R = R0W'(2*Q);

    logic            rdy_q;
    logic            adv;
    logic            in_fire;
    logic            out_fire;

    logic            v1_q;
    logic [DW-1:0]   a1_q;
    logic [TAGW-1:0] tag1_q;
    logic [MUL_W-1:0] p_d, p1_q;

    logic            v2_q;
    logic [R0W-1:0]  r0_d, r0_q;
    logic [TAGW-1:0] tag2_q;

    logic            dout_valid_q;
    logic [QW-1:0]   r_d, dout_r_q;
    logic [TAGW-1:0] dout_tag_q;
    logic [CNTW-1:0] cnt_q;

    // rdy_q keeps din_ready low during reset and until the first edge after release.
    assign adv      = !dout_valid_q || bus.dout_ready;
    assign in_fire  = bus.din_valid && rdy_q && adv;
    assign out_fire = dout_valid_q && bus.dout_ready;

    assign p_d  = MUL_W'(bus.din_a) * MUL_W'(MU);
    // The true remainder estimate is below 3Q, so truncating the wide difference is exact.
    assign r0_d = R0W'(MUL_W'(a1_q) - (p1_q >> DW) * MUL_W'(Q));

    always_comb begin
        r_d = QW'(r0_q);
        if (r0_q >= Q2_R) begin
            r_d = QW'(r0_q - Q2_R);
        end else if (r0_q >= Q_R) begin
            r_d = QW'(r0_q - Q_R);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q  <= 1'b0;
            v1_q   <= 1'b0;
            a1_q   <= '0;
            tag1_q <= '0;
            p1_q   <= '0;
            v2_q   <= 1'b0;
            r0_q   <= '0;
            tag2_q <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (adv) begin
                v1_q <= in_fire;
                if (in_fire) begin
                    a1_q   <= bus.din_a;
                    tag1_q <= bus.din_tag;
                    p1_q   <= p_d;
                end
                v2_q <= v1_q;
                if (v1_q) begin
                    r0_q   <= r0_d;
                    tag2_q <= tag1_q;
                end
            end
        end
    end

    // Output registers keep their last value across bubbles and stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid_q <= 1'b0;
            dout_r_q     <= '0;
            dout_tag_q   <= '0;
            cnt_q        <= '0;
        end else begin
            if (adv) begin
                dout_valid_q <= v2_q;
                if (v2_q) begin
                    dout_r_q   <= r_d;
                    dout_tag_q <= tag2_q;
                end
            end
            if (out_fire) begin
                cnt_q <= cnt_q + CNTW'(1);
            end
        end
    end

    assign bus.din_ready  = rdy_q && adv;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_r     = dout_r_q;
    assign bus.dout_tag   = dout_tag_q;
    assign bus.res_cnt    = cnt_q;
endmodule

// File: tb/tb_barret_reduce_pipe.sv
// Self-checking bench for barret_reduce_pipe: cycle-level reference model built on
// plain modulo arithmetic, plus hand-written sequences for reset, bubbles and stalls.
module tb_barret_reduce_pipe;
    localparam int Q    = 103;
    localparam int QW   = 7;
    localparam int DW   = 14;
    localparam int TAGW = 4;
    localparam int CNTW = 16;

    typedef struct {
        logic [DW-1:0]   a;
        logic [TAGW-1:0] tag;
        logic [QW-1:0]   r;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    barret_reduce_pipe_if #(.DW(DW), .QW(QW), .TAGW(TAGW), .CNTW(CNTW)) bus ();

    barret_reduce_pipe #(.Q(Q), .QW(QW), .DW(DW), .TAGW(TAGW), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vecCnt  = 0;
    int missCnt = 0;

    // Reference: a three-slot delay line that only moves when the output is free or taken.
    logic [2:0]      mV;
    int              mRes [2];
    logic [TAGW-1:0] mTag [2];
    int              mR;
    logic [TAGW-1:0] mT;
    logic [CNTW-1:0] mCnt;
    logic            mRdy;
    logic            lastAcc;
    int              dutOut;

    vec_t            tbl [6];
    logic            pat [7];
    logic [DW-1:0]   ops [20];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCnt++;
        if (act !== exp) begin
            missCnt++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelClear();
        mV   = '0;
        mR   = 0;
        mT   = '0;
        mCnt = '0;
        mRdy = 1'b0;
    endtask

    task automatic modelStep(input logic v, input logic [DW-1:0] a, input logic [TAGW-1:0] t,
                             input logic ordy);
        logic adv;
        adv     = !mV[2] || ordy;
        lastAcc = v && mRdy && adv;
        if (mV[2] && ordy) mCnt = mCnt + 1'b1;
        if (adv) begin
            if (mV[1]) begin
                mR = mRes[1];
                mT = mTag[1];
            end
            mV[2]   = mV[1];
            mV[1]   = mV[0];
            mRes[1] = mRes[0];
            mTag[1] = mTag[0];
            mV[0]   = lastAcc;
            if (lastAcc) begin
                mRes[0] = int'(a) % Q;
                mTag[0] = t;
            end
        end
        mRdy = 1'b1;
    endtask

    task automatic checkOutput();
        checkVal("dout_valid", 32'(bus.dout_valid), 32'(mV[2]));
        checkVal("dout_r",     32'(bus.dout_r),     mR);
        checkVal("dout_tag",   32'(bus.dout_tag),   32'(mT));
        checkVal("res_cnt",    32'(bus.res_cnt),    32'(mCnt));
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] a, input logic [TAGW-1:0] t,
                                 input logic ordy);
        bus.din_valid  = v;
        bus.din_a      = a;
        bus.din_tag    = t;
        bus.dout_ready = ordy;
        #1;
        checkVal("din_ready", 32'(bus.din_ready), 32'(mRdy && (!mV[2] || ordy)));
        if (bus.dout_valid && ordy) dutOut++;
        @(posedge clk);
        modelStep(v, a, t, ordy);
        #1;
        checkOutput();
    endtask

    task automatic doReset(input int cycles);
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b1;
        rst_n = 1'b0;
        modelClear();
        #1;
        checkVal("rst_valid", 32'(bus.dout_valid), 0);
        checkVal("rst_ready", 32'(bus.din_ready), 0);
        checkVal("rst_cnt",   32'(bus.res_cnt), 0);
        repeat (cycles) @(posedge clk);
        #1;
        checkOutput();
        checkVal("rst_ready_hold", 32'(bus.din_ready), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int idx;
        int cyc;

        tbl[0] = '{a: 14'd0,     tag: 4'd0, r: 7'd0};
        tbl[1] = '{a: 14'd102,   tag: 4'd1, r: 7'd102};
        tbl[2] = '{a: 14'd103,   tag: 4'd2, r: 7'd0};
        tbl[3] = '{a: 14'd205,   tag: 4'd3, r: 7'd102};
        tbl[4] = '{a: 14'd10608, tag: 4'd4, r: 7'd102};
        tbl[5] = '{a: 14'd16383, tag: 4'd5, r: 7'd6};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 20; i++) ops[i] = DW'($urandom_range(16383, 0));

        bus.din_valid  = 1'b0;
        bus.din_a      = '0;
        bus.din_tag    = '0;
        bus.dout_ready = 1'b1;
        dutOut         = 0;
        lastAcc        = 1'b0;
        modelClear();
        #2;

        $display("[TB] reset");
        doReset(4);
        applyStimulus(1'b0, '0, '0, 1'b1);
        #1;
        checkVal("t1_din_ready", 32'(bus.din_ready), 1);

        $display("[TB] boundary table");
        for (int c = 0; c < 9; c++) begin
            if (c < 6) applyStimulus(1'b1, tbl[c].a, tbl[c].tag, 1'b1);
            else       applyStimulus(1'b0, '0, '0, 1'b1);
            if (c >= 2 && c < 8) begin
                checkVal("t2_valid", 32'(bus.dout_valid), 1);
                checkVal("t2_r",     32'(bus.dout_r),     32'(tbl[c-2].r));
                checkVal("t2_tag",   32'(bus.dout_tag),   32'(tbl[c-2].tag));
            end
        end

        $display("[TB] exhaustive stream");
        doReset(2);
        applyStimulus(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 16384; i++) applyStimulus(1'b1, DW'(i), TAGW'(i), 1'b1);
        repeat (3) applyStimulus(1'b0, '0, '0, 1'b1);
        checkVal("t3_res_cnt", 32'(bus.res_cnt), 16384);

        $display("[TB] backpressure");
        idx    = 0;
        cyc    = 0;
        dutOut = 0;
        while ((idx < 20 || mV != 3'b000) && cyc < 400) begin
            if (idx < 20) applyStimulus(1'b1, ops[idx], TAGW'(idx), 1'($urandom_range(1, 0)));
            else          applyStimulus(1'b0, '0, '0, 1'($urandom_range(1, 0)));
            if (lastAcc) idx++;
            cyc++;
        end
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkVal("t4_accepted", idx, 20);
        checkVal("t4_delivered", dutOut, 20);

        $display("[TB] bubbles");
        for (int c = 0; c < 10; c++) begin
            if (c < 7) applyStimulus(pat[c], DW'($urandom_range(16383, 0)), TAGW'(c), 1'b1);
            else       applyStimulus(1'b0, '0, '0, 1'b1);
            if (c >= 2 && c < 9) checkVal("t5_valid", 32'(bus.dout_valid), 32'(pat[c-2]));
        end

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(500 + i), TAGW'(i), 1'b1);
        rst_n = 1'b0;
        modelClear();
        #1;
        checkVal("t6_valid", 32'(bus.dout_valid), 0);
        checkVal("t6_cnt",   32'(bus.res_cnt), 0);
        checkVal("t6_ready", 32'(bus.din_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) applyStimulus(1'b0, '0, '0, 1'b1);
        applyStimulus(1'b1, 14'd206, 4'd9, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkVal("t6_out_valid", 32'(bus.dout_valid), 1);
        checkVal("t6_out_r",     32'(bus.dout_r), 0);
        checkVal("t6_out_tag",   32'(bus.dout_tag), 9);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkVal("t6_cnt_end",   32'(bus.res_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end
endmodule
